// File: rtl/pretu_tile_sched_if.sv
// ---------------------------------------------------------------------------
// pretu_tile_sched_if
//   Stream bundle around the Winograd PreTu tile sequencer.
//   Input side : in_valid / in_ready / in_row   (one 4-element row per beat)
//   Output side: out_valid / out_ready / out_tile / out_tag (one 4x4 tile)
//   Modports:
//     slave  - the sequencer (consumes rows, produces tiles)
//     master - the environment (tile fetcher + EWMM consumer)
// ---------------------------------------------------------------------------
interface pretu_tile_sched_if #(
  parameter int DW     = 16,
  parameter int TCNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*DW-1:0]         in_row;
  logic                    out_valid;
  logic                    out_ready;
  logic [16*(DW+2)-1:0]    out_tile;
  logic [TCNT_W-1:0]       out_tag;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_tile, out_tag
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_tile, out_tag
  );
endinterface

// File: rtl/pretu_tile_sched.sv
// ---------------------------------------------------------------------------
// pretu_tile_sched
//   Sequencer for the 4x4 Winograd input pre-transform (Y = B^T * X * B).
//   Rows arrive serially and are assembled into a 2-entry ping-pong buffer.
//   One shared combinational PreTu reads the buffer selected by the read
//   pointer; its result is captured in a registered valid/ready output stage.
//   Ports:
//     clk      - rising-edge clock
//     rst_n    - asynchronous active-low reset
//     soft_clr - synchronous flush of all in-flight state (highest priority)
//     bus      - stream bundle (slave modport): rows in, tiles + tags out
//     busy     - a buffer is full, a partial tile is loading, or out_valid
//   Element layout: X[r][c] = in_row[c*DW +: DW] of row r,
//                   Y[r][c] = out_tile[(4*r+c)*(DW+2) +: DW+2].
// ---------------------------------------------------------------------------
module pretu_tile_sched #(
  parameter int DW     = 16,
  parameter int TCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                soft_clr,
  pretu_tile_sched_if.slave   bus,
  output logic                busy
);

  localparam int OW = DW + 2;     // output element width
  localparam int RW = 4 * DW;     // one input row
  localparam int TW = 16 * OW;    // one output tile

  // Widen a DW-bit signed value by one bit (sign extension).
  function automatic logic [DW:0] sx1(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  // Widen a (DW+1)-bit signed value by one bit (sign extension).
  function automatic logic [DW+1:0] sx2(input logic [DW:0] v);
    return {v[DW], v};
  endfunction

  // Winograd F(2x2,3x3) input transform. B^T rows are
  // [1 0 -1 0], [0 1 1 0], [0 -1 1 0], [0 1 0 -1]; the row pass grows to
  // DW+1 bits, the column pass to DW+2 bits, so nothing can overflow.
  function automatic logic [TW-1:0] pretu(input logic [16*DW-1:0] x);
    logic [DW-1:0] xe [4][4];
    logic [DW:0]   t  [4][4];
    logic [DW+1:0] y  [4][4];
    logic [TW-1:0] res;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        xe[r][c] = x[(4*r+c)*DW +: DW];
      end
    end
    // Row pass: T = B^T * X
    for (int c = 0; c < 4; c++) begin
      t[0][c] = sx1(xe[0][c]) - sx1(xe[2][c]);
      t[1][c] = sx1(xe[1][c]) + sx1(xe[2][c]);
      t[2][c] = sx1(xe[2][c]) - sx1(xe[1][c]);
      t[3][c] = sx1(xe[1][c]) - sx1(xe[3][c]);
    end
    // Column pass: Y = T * B
    for (int r = 0; r < 4; r++) begin
      y[r][0] = sx2(t[r][0]) - sx2(t[r][2]);
      y[r][1] = sx2(t[r][1]) + sx2(t[r][2]);
      y[r][2] = sx2(t[r][2]) - sx2(t[r][1]);
      y[r][3] = sx2(t[r][1]) - sx2(t[r][3]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[(4*r+c)*OW +: OW] = y[r][c];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]                  row_cnt_q,   row_cnt_d;
  logic                        wr_ptr_q,    wr_ptr_d;
  logic                        rd_ptr_q,    rd_ptr_d;
  logic [1:0]                  buf_full_q,  buf_full_d;
  logic [1:0][TCNT_W-1:0]      buf_tag_q,   buf_tag_d;
  logic [TCNT_W-1:0]           tag_cnt_q,   tag_cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic [TW-1:0]               out_tile_q,  out_tile_d;
  logic [TCNT_W-1:0]           out_tag_q,   out_tag_d;
  logic                        busy_q,      busy_d;
  logic [1:0][3:0][RW-1:0]     buf_q;       // [buffer][row]

  logic                        in_ready_s;
  logic                        accept_s;
  logic                        load_s;
  logic                        buf_wr_s;
  logic [TW-1:0]               pretu_s;

  // in_ready depends on registered flags only, so there is no combinational
  // path from out_ready; a freed buffer shows up one cycle after the load.
  assign in_ready_s = ~buf_full_q[wr_ptr_q];
  assign accept_s   = bus.in_valid & in_ready_s;
  assign load_s     = buf_full_q[rd_ptr_q] & (~out_valid_q | bus.out_ready);
  assign buf_wr_s   = accept_s & ~soft_clr;

  // Packed [3:0][RW-1:0] places row r at bits r*RW, matching X[r][c] layout.
  assign pretu_s    = pretu(buf_q[rd_ptr_q]);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tile  = out_tile_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = busy_q;

  // Next-state for row assembly, ping-pong flags, tag counter and output stage.
  always_comb begin
    row_cnt_d   = row_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_full_d  = buf_full_q;
    buf_tag_d   = buf_tag_q;
    tag_cnt_d   = tag_cnt_q;
    out_valid_d = out_valid_q;
    out_tile_d  = out_tile_q;
    out_tag_d   = out_tag_q;

    if (soft_clr) begin
      // Flush wins over every other update; the handshake this cycle is void.
      row_cnt_d   = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      buf_full_d  = 2'b00;
      tag_cnt_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      // Writer side: last row seals the buffer and stamps its tag.
      if (accept_s) begin
        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd3) begin
          buf_full_d[wr_ptr_q] = 1'b1;
          buf_tag_d[wr_ptr_q]  = tag_cnt_q;
          tag_cnt_d            = tag_cnt_q + TCNT_W'(1);
          wr_ptr_d             = ~wr_ptr_q;
        end else begin
          buf_full_d[wr_ptr_q] = buf_full_q[wr_ptr_q];
        end
      end else begin
        row_cnt_d = row_cnt_q;
      end

      // Reader side: the writer only ever seals an empty buffer, so when
      // both sides act in one cycle they touch different entries.
      if (load_s) begin
        out_tile_d           = pretu_s;
        out_tag_d            = buf_tag_q[rd_ptr_q];
        out_valid_d          = 1'b1;
        buf_full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d             = ~rd_ptr_q;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end

    busy_d = (|buf_full_d) | (row_cnt_d != 2'd0) | out_valid_d;
  end

  // Control and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q   <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      buf_full_q  <= 2'b00;
      buf_tag_q   <= '0;
      tag_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_tile_q  <= '0;
      out_tag_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_full_q  <= buf_full_d;
      buf_tag_q   <= buf_tag_d;
      tag_cnt_q   <= tag_cnt_d;
      out_valid_q <= out_valid_d;
      out_tile_q  <= out_tile_d;
      out_tag_q   <= out_tag_d;
      busy_q      <= busy_d;
    end
  end

  // Ping-pong row storage; a full buffer is never selected for writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (buf_wr_s) begin
      buf_q[wr_ptr_q][row_cnt_q] <= bus.in_row;
    end
  end

endmodule
